uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with parity/framing/overrun flags; ports: bclk, rst_n, rx, rate_sel, pen, eps, wls, rx_rd in; rx_dout, rx_done, rx_valid, pe, fe, oe, rx_busy out
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       bclk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rate_sel,
  input  logic       pen,
  input  logic       eps,
  input  logic [1:0] wls,
  input  logic       rx_rd,
  output logic [7:0] rx_dout,
  output logic       rx_done,
  output logic       rx_valid,
  output logic       pe,
  output logic       fe,
  output logic       oe,
  output logic       rx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic rx_s, rx_q, rate_sel_s1, pen_s1, eps_s1, par_r, par_nx, tick, complete, par_err;
  logic [1:0] wls_s1;
  logic [3:0] count, count_nx, last, mid;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] data_r, data_nx, word;
  assign rx_s = rx_sync[SYNC_STAGES-1];
  assign last = rate_sel_s1 ? 4'd12 : 4'd15;
  assign mid = rate_sel_s1 ? 4'd5 : 4'd7;
  assign tick = count == last;
  assign complete = state == STOP && tick;
  assign word = data_r & (8'hff >> (2'd3 - wls_s1));
  assign par_err = pen_s1 & (par_r ^ (^word) ^ ~eps_s1);
  assign rx_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    count_nx = count + 4'd1;
    bit_idx_nx = bit_idx;
    data_nx = data_r;
    par_nx = par_r;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (rx_q & ~rx_s) state_nx = START;
      end
      START: if (count == mid) begin
        count_nx = '0;
        state_nx = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        count_nx = '0;
        data_nx[bit_idx] = rx_s;
        bit_idx_nx = bit_idx + 3'd1;
        if (bit_idx == {1'b0, wls_s1} + 3'd4) begin
          bit_idx_nx = '0;
          state_nx = pen_s1 ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        count_nx = '0;
        par_nx = rx_s;
        state_nx = STOP;
      end
      STOP: if (tick) begin
        count_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1;
      rx_q <= 1'b1;
      {rate_sel_s1, pen_s1, eps_s1, wls_s1} <= '0;
      state <= IDLE;
      count <= '0;
      bit_idx <= '0;
      data_r <= '0;
      par_r <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
      rx_q <= rx_s;
      {rate_sel_s1, pen_s1, eps_s1, wls_s1} <= {rate_sel, pen, eps, wls};
      state <= state_nx;
      count <= count_nx;
      bit_idx <= bit_idx_nx;
      data_r <= data_nx;
      par_r <= par_nx;
    end
  end
  // A read coinciding with completion loses: the new word is valid and no overrun is flagged.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dout <= '0;
      {rx_done, rx_valid, pe, fe, oe} <= '0;
    end else if (complete) begin
      rx_done <= 1'b1;
      rx_dout <= word;
      pe <= par_err;
      fe <= ~rx_s;
      rx_valid <= 1'b1;
      oe <= rx_valid & ~rx_rd;
    end else begin
      rx_done <= 1'b0;
      if (rx_rd & rx_valid) begin
        rx_valid <= 1'b0;
        oe <= 1'b0;
      end
    end
  end
endmodule
